// File: rtl/jtdd_adpcm_pkg.sv
// Shared constants for the ADPCM encoder: OKI step table, index adjust
// table, clamp limits and the encoder FSM states.
package jtdd_adpcm_pkg;

  localparam logic signed [7:0]  IDX_MAX = 8'sd48;
  localparam logic signed [13:0] PCM_MIN = -14'sd2048;
  localparam logic signed [13:0] PCM_MAX = 14'sd2047;

  localparam logic [10:0] STEP [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [7:0] ADJ [8] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DIFF,
    QUANT,
    UPD,
    WR
  } state_t;

endpackage

// File: rtl/jtdd_adpcm_enc_if.sv
// Control, sample stream and sample-memory write bus of the ADPCM encoder.
// The encoder uses the master modport, the controlling host the slave one.
interface jtdd_adpcm_enc_if;
  logic        start;
  logic        stop;
  logic [7:0]  start_blk;
  logic [7:0]  end_blk;
  logic [11:0] pcm;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        mem_ok;
  logic        busy;
  logic [3:0]  code;

  modport master (
    input  start, stop, start_blk, end_blk, pcm, pcm_valid, mem_ok,
    output pcm_ready, mem_addr, mem_dout, mem_we, busy, code
  );

  modport slave (
    output start, stop, start_blk, end_blk, pcm, pcm_valid, mem_ok,
    input  pcm_ready, mem_addr, mem_dout, mem_we, busy, code
  );
endinterface

// File: rtl/jtdd_adpcm_quant.sv
// ADPCM datapath: difference, 3-bit quantisation and decoder-model update
// of predictor and step index. Each stage is enabled by the owning FSM.
module jtdd_adpcm_quant
  import jtdd_adpcm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        diff_en,
  input  logic        quant_en,
  input  logic        upd_en,
  input  logic [11:0] pcm,
  output logic [3:0]  code_new,
  output logic [3:0]  code
);

  logic signed [11:0] sample;
  logic signed [11:0] predictor;
  logic [5:0]         idx;
  logic [10:0]        step;
  logic               sign;
  logic [12:0]        mag;
  logic               b2, b1, b0;

  logic [12:0]        diff, mag_nxt, r1, r2;
  logic               b2_nxt, b1_nxt, b0_nxt;
  logic [11:0]        delta;
  logic signed [13:0] psum, psat;
  logic signed [7:0]  inext;
  logic [5:0]         idx_nxt;

  assign code_new = {sign, b2, b1, b0};

  // Stage arithmetic for DIFF, QUANT and UPD
  always_comb begin
    diff    = {sample[11], sample} - {predictor[11], predictor};
    mag_nxt = diff[12] ? (13'd0 - diff) : diff;

    b2_nxt = mag >= {2'b00, step};
    r1     = b2_nxt ? (mag - {2'b00, step}) : mag;
    b1_nxt = r1 >= {3'b000, step[10:1]};
    r2     = b1_nxt ? (r1 - {3'b000, step[10:1]}) : r1;
    b0_nxt = r2 >= {4'b0000, step[10:2]};

    delta = {4'b0000, step[10:3]}
          + (b0 ? {3'b000, step[10:2]} : 12'd0)
          + (b1 ? {2'b00,  step[10:1]} : 12'd0)
          + (b2 ? {1'b0,   step}       : 12'd0);
    psum  = sign ? ({{2{predictor[11]}}, predictor} - {2'b00, delta})
                 : ({{2{predictor[11]}}, predictor} + {2'b00, delta});
    psat  = (psum < PCM_MIN) ? PCM_MIN : (psum > PCM_MAX) ? PCM_MAX : psum;

    inext   = $signed({2'b00, idx}) + ADJ[{b2, b1, b0}];
    idx_nxt = inext[7] ? 6'd0 : (inext > IDX_MAX) ? IDX_MAX[5:0] : inext[5:0];
  end

  // Pipeline registers and decoder-model state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample    <= '0;
      predictor <= '0;
      idx       <= '0;
      step      <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      b2        <= 1'b0;
      b1        <= 1'b0;
      b0        <= 1'b0;
      code      <= '0;
    end else begin
      if (clear) begin
        predictor <= '0;
        idx       <= '0;
      end
      if (load) sample <= pcm;
      if (diff_en) begin
        step <= STEP[idx];
        sign <= diff[12];
        mag  <= mag_nxt;
      end
      if (quant_en) begin
        b2 <= b2_nxt;
        b1 <= b1_nxt;
        b0 <= b0_nxt;
      end
      if (upd_en) begin
        predictor <= psat[11:0];
        idx       <= idx_nxt;
        code      <= code_new;
      end
    end
  end

endmodule

// File: rtl/jtdd_adpcm_enc.sv
// ADPCM encoder top: sequencing FSM, nibble packing and sample-memory
// write handshake around the jtdd_adpcm_quant datapath.
module jtdd_adpcm_enc
  import jtdd_adpcm_pkg::*;
#(
  parameter bit END_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  jtdd_adpcm_enc_if.master bus
);

  state_t     state;
  logic [7:0] blk, end_r, blk_nxt;
  logic [8:0] byte_cnt;
  logic       nib_sel;
  logic [3:0] hi;
  logic [7:0] mem_dout;
  logic       mem_we, pcm_ready, busy;
  logic       stop_pend;
  logic [3:0] code_new;

  assign blk_nxt       = (byte_cnt == 9'h1FF) ? blk + 8'd1 : blk;
  assign bus.mem_addr  = {blk[6:0], byte_cnt};
  assign bus.mem_dout  = mem_dout;
  assign bus.mem_we    = mem_we;
  assign bus.pcm_ready = pcm_ready;
  assign bus.busy      = busy;

  jtdd_adpcm_quant u_quant (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE && bus.start && !bus.stop),
    .load     (state == WAIT && bus.pcm_valid && !bus.stop),
    .diff_en  (state == DIFF),
    .quant_en (state == QUANT),
    .upd_en   (state == UPD && !bus.stop),
    .pcm      (bus.pcm),
    .code_new (code_new),
    .code     (bus.code)
  );

  // Sequencing FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk       <= '0;
      end_r     <= '0;
      byte_cnt  <= '0;
      nib_sel   <= 1'b0;
      hi        <= '0;
      mem_dout  <= '0;
      mem_we    <= 1'b0;
      pcm_ready <= 1'b0;
      busy      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            blk       <= bus.start_blk;
            end_r     <= bus.end_blk;
            byte_cnt  <= '0;
            nib_sel   <= 1'b0;
            stop_pend <= 1'b0;
            if (bus.start_blk != bus.end_blk) begin
              state     <= WAIT;
              busy      <= 1'b1;
              pcm_ready <= 1'b1;
            end
          end
        end
        WAIT, DIFF, QUANT, UPD: begin
          if (bus.stop) begin
            // In-flight sample is dropped; only an already packed high nibble survives
            pcm_ready <= 1'b0;
            if (nib_sel && END_FLUSH) begin
              mem_dout  <= {hi, 4'h0};
              mem_we    <= 1'b1;
              nib_sel   <= 1'b0;
              stop_pend <= 1'b1;
              state     <= WR;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            case (state)
              WAIT: begin
                if (bus.pcm_valid) begin
                  pcm_ready <= 1'b0;
                  state     <= DIFF;
                end
              end
              DIFF:  state <= QUANT;
              QUANT: state <= UPD;
              UPD: begin
                if (!nib_sel) begin
                  hi        <= code_new;
                  nib_sel   <= 1'b1;
                  pcm_ready <= 1'b1;
                  state     <= WAIT;
                end else begin
                  mem_dout <= {hi, code_new};
                  mem_we   <= 1'b1;
                  nib_sel  <= 1'b0;
                  state    <= WR;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
        WR: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (bus.mem_ok) begin
            mem_we   <= 1'b0;
            byte_cnt <= byte_cnt + 9'd1;
            blk      <= blk_nxt;
            if (blk_nxt == end_r || stop_pend || bus.stop) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pcm_ready <= 1'b1;
              state     <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_adpcm_enc.sv
// Scoreboard bench for jtdd_adpcm_enc: stimulus pushes expected codes and
// memory writes, a negedge monitor pops and compares them.
module tb_jtdd_adpcm_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtdd_adpcm_enc_if bus();

  jtdd_adpcm_enc #(.END_FLUSH(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [3:0]         code;
    logic signed [11:0] pred;
    logic [5:0]         idx;
  } smp_t;

  wr_t         wr_q[$];
  smp_t        smp_q[$];
  int unsigned due_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Monitor: code/predictor/index four cycles after each accept, and every acknowledged write
  always @(negedge clk) begin
    smp_t s;
    wr_t  w;
    cyc = cyc + 1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      if (smp_q.size() == 0) fail_now("unexpected_sample");
      else begin
        s = smp_q.pop_front();
        check("code", 32'(bus.code), 32'(s.code));
        check("predictor", 32'(dut.u_quant.predictor), 32'(s.pred));
        check("idx", 32'(dut.u_quant.idx), 32'(s.idx));
      end
    end
    if (bus.pcm_valid && bus.pcm_ready) due_q.push_back(cyc + 4);
    if (bus.mem_we && bus.mem_ok) begin
      if (wr_q.size() == 0) fail_now("unexpected_write");
      else begin
        w = wr_q.pop_front();
        check("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
        check("mem_dout", 32'(bus.mem_dout), 32'(w.data));
      end
    end
  end

  task automatic pulse_start(input logic [7:0] sb, input logic [7:0] eb);
    @(posedge clk); #1;
    bus.start_blk = sb;
    bus.end_blk   = eb;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic send(input logic [11:0] s, input logic [3:0] c,
                      input logic signed [11:0] p, input logic [5:0] ix);
    smp_t e;
    bit ok = 1'b0;
    e.code = c;
    e.pred = p;
    e.idx  = ix;
    smp_q.push_back(e);
    bus.pcm       = s;
    bus.pcm_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.pcm_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("send_timeout");
    @(posedge clk); #1;
    bus.pcm_valid = 1'b0;
  endtask

  task automatic wait_due();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (due_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("sample_drain_timeout");
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (due_q.size() == 0 && wr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.start_blk = '0;
    bus.end_blk   = '0;
    bus.pcm       = '0;
    bus.pcm_valid = 1'b0;
    bus.mem_ok    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pcm_ready", 32'(bus.pcm_ready), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_dout", 32'(bus.mem_dout), 0);
    check("rst_code", 32'(bus.code), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1000, 0 -> codes 7, B; one byte 0x7B at 0x0000
    pulse_start(8'd0, 8'd1);
    check("busy_rise", 32'(bus.busy), 1);
    exp_write(16'h0000, 8'h7B);
    send(12'd1000, 4'h7, 12'sd30, 6'd8);
    send(12'd0, 4'hB, 12'sd1, 6'd7);
    drain();
    pulse_stop();
    wait_idle();

    // -1000 from reset, then flush of the lone high nibble
    pulse_start(8'h20, 8'h21);
    send(-12'sd1000, 4'hF, -12'sd30, 6'd8);
    wait_due();
    pulse_stop();
    exp_write(16'h4000, 8'hF0);
    drain();
    wait_idle();

    // 0 from reset: index clamps at 0
    pulse_start(8'h30, 8'h31);
    send(12'd0, 4'h0, 12'sd2, 6'd0);
    wait_due();
    pulse_stop();
    exp_write(16'h6000, 8'h00);
    drain();
    wait_idle();

    // start_blk == end_blk: nothing happens
    pulse_start(8'd7, 8'd7);
    check("empty_busy", 32'(bus.busy), 0);
    repeat (5) @(negedge clk);
    check("empty_pcm_ready", 32'(bus.pcm_ready), 0);

    // Full block 3: zero samples alternate codes 0/8, every byte 0x08
    pulse_start(8'd3, 8'd4);
    for (int i = 0; i < 512; i++) exp_write(16'h0600 + 16'(i), 8'h08);
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) send(12'd0, 4'h0, 12'sd2, 6'd0);
      else            send(12'd0, 4'h8, 12'sd0, 6'd0);
    end
    wait_idle();
    drain();
    repeat (4) @(negedge clk);
    check("blk_end_busy", 32'(bus.busy), 0);
    check("blk_end_pcm_ready", 32'(bus.pcm_ready), 0);

    // Write held off by mem_ok low for 10 cycles
    @(posedge clk); #1;
    bus.mem_ok = 1'b0;
    pulse_start(8'd5, 8'd6);
    exp_write(16'h0A00, 8'h7B);
    send(12'd1000, 4'h7, 12'sd30, 6'd8);
    send(12'd0, 4'hB, 12'sd1, 6'd7);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("hold_mem_we_timeout");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_mem_we", 32'(bus.mem_we), 1);
      check("hold_mem_addr", 32'(bus.mem_addr), 32'h0A00);
      check("hold_mem_dout", 32'(bus.mem_dout), 32'h7B);
      check("hold_pcm_ready", 32'(bus.pcm_ready), 0);
    end
    @(posedge clk); #1;
    bus.mem_ok = 1'b1;
    drain();
    pulse_stop();
    wait_idle();

    // Three samples then stop: second byte is {hi,0}; mid-run start ignored
    pulse_start(8'h10, 8'h20);
    exp_write(16'h2000, 8'h7B);
    exp_write(16'h2001, 8'hF0);
    send(12'd1000, 4'h7, 12'sd30, 6'd8);
    send(12'd0, 4'hB, 12'sd1, 6'd7);
    pulse_start(8'h33, 8'h34);
    send(-12'sd1000, 4'hF, -12'sd55, 6'd15);
    wait_due();
    pulse_stop();
    drain();
    wait_idle();
    repeat (3) @(negedge clk);
    check("stop_busy", 32'(bus.busy), 0);
    check("stop_pcm_ready", 32'(bus.pcm_ready), 0);

    check("wr_queue_empty", 32'(wr_q.size()), 0);
    check("smp_queue_empty", 32'(smp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_adpcm_enc.md
# jtdd_adpcm_enc

Writer side of the 4-bit ADPCM sample stream consumed by the sound playback block. Encodes a stream of signed 12-bit PCM samples into OKI/MSM5205-compatible ADPCM nibbles and packs two per byte. Writes the bytes to sample memory in the same block/offset layout the player reads. Used for in-system sample capture and for generating self-consistent ROM images in simulation.

## Interface
Parameters:
- `END_FLUSH`, default 1: when 1, a pending high nibble is written out on stop/end, padded with low nibble 0.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; loads `start_blk`/`end_blk` and begins encoding.
- `stop` in 1: one-cycle pulse; aborts encoding (flushes per `END_FLUSH`).
- `start_blk` in 8: first 512-byte block written.
- `end_blk` in 8: exclusive end block; encoding finishes when the block counter reaches it.
- `pcm` in 12: signed input sample.
- `pcm_valid` in 1: sample available.
- `pcm_ready` out 1: sample accepted on a cycle where `pcm_valid && pcm_ready`.
- `mem_addr` out 16: `{blk[6:0], byte_cnt[8:0]}`.
- `mem_dout` out 8: packed byte, high nibble = earlier sample.
- `mem_we` out 1: write request, held until acknowledged.
- `mem_ok` in 1: write accepted on a cycle where `mem_we && mem_ok`.
- `busy` out 1: high from `start` until return to IDLE.
- `code` out 4: last generated nibble (debug).

## Operation
- FSM states: IDLE, WAIT, DIFF, QUANT, UPD, WR.
- IDLE: `busy=0`, `pcm_ready=0`. A `start` pulse causes the following:
  - blk←start_blk, byte_cnt←0, nib_sel←0.
  - predictor←0, idx←0.
  - Next state WAIT.
  - If start_blk==end_blk, go to IDLE instead; no writes occur.
- WAIT: `pcm_ready=1`. A handshake latches `pcm` → DIFF.
- DIFF: diff = pcm − predictor, 13-bit signed. Latch step = STEP[idx] and sign = diff<0. Take d=|diff| as 13-bit unsigned.
- QUANT: compute the code bits:
  - b2 = d≥step. If set, d−=step.
  - b1 = d≥step>>1. If set, d−=step>>1.
  - b0 = d≥step>>2.
  - code={sign,b2,b1,b0}.
- UPD: apply the decoder model, identical to the player's:
  - delta = (step>>3) + (b0?step>>2:0) + (b1?step>>1:0) + (b2?step:0).
  - predictor ±= delta, saturated to [−2048, 2047].
  - idx += ADJ[code[2:0]], where ADJ = {−1,−1,−1,−1,2,4,6,8}, clamped to [0,48].
  - If nib_sel==0: hi←code, nib_sel←1, → WAIT.
  - Else: mem_dout←{hi,code}, nib_sel←0, → WR.
- WR: `mem_we=1` until `mem_ok`. On acknowledge:
  - byte_cnt++.
  - On wrap 511→0, blk++.
  - If the new blk==end_blk, → IDLE. Otherwise → WAIT.
- STEP: the 49-entry OKI table 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552.
- `stop` in WAIT/DIFF/QUANT/UPD:
  - Any sample in flight is discarded.
  - If nib_sel==1 and END_FLUSH, write {hi,4'h0} through WR, then → IDLE.
  - Otherwise → IDLE at once.
- `stop` in WR: the current write completes, then → IDLE.
- `start` while busy: ignored.
- `start` and `stop` in the same cycle: `stop` wins.
- Block counter is 8 bits. Address uses blk[6:0], so block 128 aliases to 0, the same as the reader.

## Timing
- Reset values: `busy=0`, `pcm_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_dout=0`, `code=0`. Internal state: predictor=0, idx=0, FSM=IDLE.
- Accept at cycle N → DIFF at N+1, QUANT at N+2, UPD at N+3.
  - `code` updates at N+4.
  - `pcm_ready` is high again at N+4 for an even sample.
  - `mem_we` is asserted at N+4 for an odd sample.
- Max throughput: one sample per 4 cycles. Add +1 cycle per byte when `mem_ok` is already high.
- `mem_addr`/`mem_dout` are stable for the whole time `mem_we` is high.
- `busy` rises the cycle after `start` and falls the cycle the FSM enters IDLE.

## Structure
- Shared package `jtdd_adpcm_pkg`: STEP table, ADJ table, IDX_MAX=48, PCM_MIN/PCM_MAX constants, FSM state enum. The same tables are used by any future software-model check.
- One natural sub-module, `jtdd_adpcm_quant`: holds the DIFF/QUANT/UPD datapath (predictor, idx, step lookup). The top keeps the FSM, packing and memory handshake.

## Test plan
- From reset, start_blk=0, end_blk=1; samples 1000, 0 with mem_ok tied 1:
  - Codes 0x7 then 0xB.
  - Predictor 30 then 1; idx 8 then 7.
  - One write, addr 0x0000, data 0x7B.
- First sample −1000 → code 0xF, predictor −30, idx 8.
- Sample 0 from reset → code 0x0, predictor 2, idx stays 0 (clamp).
- start_blk=3, end_blk=4, 1024 samples:
  - Addresses 0x0600..0x07FF written in order.
  - `busy` falls after the last write; `pcm_ready` stays 0 afterwards.
- mem_ok held low 10 cycles during WR: `mem_we`, `mem_addr` and `mem_dout` stay stable; `pcm_ready` stays 0.
- Three samples then `stop` with END_FLUSH=1: two writes, the second {hi,0}, then IDLE. Repeat `start` mid-run: ignored.
